// File: rtl/ddr3_cmd_pkg.sv
// ddr3_cmd_pkg: DDR3 pin command encodings ({CS,RAS,CAS,WE}), sequencer states and the A10 bit index.
package ddr3_cmd_pkg;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam int A10 = 10;
    typedef enum logic [2:0] {S_IDLE, S_PRE_ONE, S_ACT, S_WAIT, S_ISSUE, S_PREA, S_REF} state_t;
endpackage

// File: rtl/ddr3_cmd_sequencer_if.sv
// ddr3_cmd_sequencer_if: valid/ready host request port of the DDR3 command sequencer.
interface ddr3_cmd_sequencer_if #(
    parameter int BA_W  = 3,
    parameter int ROW_W = 14,
    parameter int COL_W = 10
);
    logic             valid;
    logic             ready;
    logic             write;
    logic             ap;
    logic [BA_W-1:0]  ba;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    modport master(output valid, write, ap, ba, row, col, input ready);
    modport slave(input valid, write, ap, ba, row, col, output ready);
endinterface

// File: rtl/ddr3_refresh_timer.sv
// ddr3_refresh_timer: free-running tREFI counter raising a refresh request and a sticky overrun flag.
module ddr3_refresh_timer #(
    parameter int T_REFI = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ref_issued,
    output logic ref_pending,
    output logic ref_overrun
);
    localparam int CW = T_REFI > 1 ? $clog2(T_REFI) : 1;
    logic [CW-1:0] cnt;
    logic          expire;
    assign expire = cnt == CW'(T_REFI - 1);
    // expiry wins over a same-cycle issue, so a fresh interval is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            ref_pending <= 1'b0;
            ref_overrun <= 1'b0;
        end else begin
            cnt         <= expire ? '0 : cnt + 1'b1;
            ref_pending <= expire | (ref_pending & ~ref_issued);
            ref_overrun <= ref_overrun | (expire & ref_pending & ~ref_issued);
        end
    end
endmodule

// File: rtl/ddr3_cmd_sequencer.sv
// ddr3_cmd_sequencer: turns host read/write requests into timed DDR3 pin commands,
// tracking open rows per bank and inserting periodic refresh.
module ddr3_cmd_sequencer
    import ddr3_cmd_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int BA_W      = 3,
    parameter int ROW_W     = 14,
    parameter int COL_W     = 10,
    parameter int T_RCD     = 5,
    parameter int T_RP      = 5,
    parameter int T_RFC     = 10,
    parameter int T_REFI    = 100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ddr3_cmd_sequencer_if.slave  req,
    output logic                 cs,
    output logic                 ras,
    output logic                 cas,
    output logic                 we,
    output logic [BA_W-1:0]      ba,
    output logic [ROW_W-1:0]     a,
    output logic                 ref_overrun,
    output logic                 busy
);
    localparam int T_AB  = T_RCD > T_RP ? T_RCD : T_RP;
    localparam int T_MAX = T_RFC > T_AB ? T_RFC : T_AB;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam logic [ROW_W-1:0] A_PREA = ROW_W'(1) << A10;

    state_t               state, target;
    logic [CW-1:0]        wcnt;
    logic [3:0]           cmd, cmd_rw;
    logic [NUM_BANKS-1:0] open_q;
    logic [ROW_W-1:0]     row_q [NUM_BANKS];
    logic [ROW_W-1:0]     a_rw;
    logic                 ref_pending, hit;

    ddr3_refresh_timer #(.T_REFI(T_REFI)) u_refresh (
        .clk(clk),
        .rst_n(rst_n),
        .ref_issued(state == S_REF),
        .ref_pending(ref_pending),
        .ref_overrun(ref_overrun)
    );

    assign hit       = open_q[req.ba] && row_q[req.ba] == req.row;
    assign req.ready = state == S_ISSUE || (state == S_IDLE && !ref_pending && req.valid && hit);
    assign busy      = state != S_IDLE;
    assign {cs, ras, cas, we} = cmd;
    assign cmd_rw    = req.write ? CMD_WR : CMD_RD;

    always_comb begin
        a_rw            = '0;
        a_rw[COL_W-1:0] = req.col;
        a_rw[A10]       = req.ap;
    end

    always_ff @(posedge clk) if (state == S_ACT) row_q[req.ba] <= req.row;

    // each command state drives its pin code on its one edge; WAIT counts T-1 down to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            target <= S_IDLE;
            wcnt   <= '0;
            cmd    <= CMD_NOP;
            ba     <= '0;
            a      <= '0;
            open_q <= '0;
        end else begin
            cmd <= CMD_NOP;
            case (state)
                S_IDLE: begin
                    if (ref_pending && |open_q) state <= S_PREA;
                    else if (ref_pending) state <= S_REF;
                    else if (req.valid && hit) begin
                        cmd <= cmd_rw;
                        ba  <= req.ba;
                        a   <= a_rw;
                        if (req.ap) open_q[req.ba] <= 1'b0;
                    end
                    else if (req.valid && open_q[req.ba]) state <= S_PRE_ONE;
                    else if (req.valid) state <= S_ACT;
                end
                S_PRE_ONE: begin
                    cmd            <= CMD_PRE;
                    ba             <= req.ba;
                    a              <= '0;
                    open_q[req.ba] <= 1'b0;
                    state          <= T_RP == 1 ? S_ACT : S_WAIT;
                    target         <= S_ACT;
                    wcnt           <= CW'(T_RP - 1);
                end
                S_ACT: begin
                    cmd            <= CMD_ACT;
                    ba             <= req.ba;
                    a              <= req.row;
                    open_q[req.ba] <= 1'b1;
                    state          <= T_RCD == 1 ? S_ISSUE : S_WAIT;
                    target         <= S_ISSUE;
                    wcnt           <= CW'(T_RCD - 1);
                end
                S_WAIT: begin
                    wcnt <= wcnt - 1'b1;
                    if (wcnt == CW'(1)) state <= target;
                end
                S_ISSUE: begin
                    cmd   <= cmd_rw;
                    ba    <= req.ba;
                    a     <= a_rw;
                    state <= S_IDLE;
                    if (req.ap) open_q[req.ba] <= 1'b0;
                end
                S_PREA: begin
                    cmd    <= CMD_PRE;
                    ba     <= '0;
                    a      <= A_PREA;
                    open_q <= '0;
                    state  <= T_RP == 1 ? S_REF : S_WAIT;
                    target <= S_REF;
                    wcnt   <= CW'(T_RP - 1);
                end
                S_REF: begin
                    cmd    <= CMD_REF;
                    state  <= T_RFC == 1 ? S_IDLE : S_WAIT;
                    target <= S_IDLE;
                    wcnt   <= CW'(T_RFC - 1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_cmd_sequencer.sv
// tb_ddr3_cmd_sequencer: directed checks of command order, edge timing, refresh and reset behaviour.
module tb_ddr3_cmd_sequencer;
    import ddr3_cmd_pkg::*;

    typedef struct {
        int         t;
        logic [3:0] c;
        logic [2:0] b;
        logic [13:0] ad;
    } ev_t;

    logic clk = 1'b0, rst_n = 1'b0, rst_b = 1'b0;
    always #5 clk = ~clk;

    ddr3_cmd_sequencer_if #(.BA_W(3), .ROW_W(14), .COL_W(10)) rq ();
    ddr3_cmd_sequencer_if #(.BA_W(3), .ROW_W(14), .COL_W(10)) rqb ();

    logic cs, ras, cas, we, ovr, busy;
    logic [2:0] ba;
    logic [13:0] a;
    logic cs_b, ras_b, cas_b, we_b, ovr_b, busy_b;
    logic [2:0] ba_b;
    logic [13:0] a_b;

    ddr3_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req(rq),
        .cs(cs), .ras(ras), .cas(cas), .we(we), .ba(ba), .a(a),
        .ref_overrun(ovr), .busy(busy)
    );

    // short refresh interval: a single tRFC spans two intervals, forcing an overrun
    ddr3_cmd_sequencer #(.T_REFI(4)) dut_b (
        .clk(clk), .rst_n(rst_b), .req(rqb),
        .cs(cs_b), .ras(ras_b), .cas(cas_b), .we(we_b), .ba(ba_b), .a(a_b),
        .ref_overrun(ovr_b), .busy(busy_b)
    );

    ev_t  log_q[$];
    logic bl[0:255];
    int   cyc = 0, r0 = 0, acc = 0, total = 0, bad = 0;

    always @(posedge clk) begin
        if (rq.valid && rq.ready) acc++;
        cyc++;
        #1;
        if ({cs, ras, cas, we} != CMD_NOP) log_q.push_back('{cyc - r0, {cs, ras, cas, we}, ba, a});
        if (cyc - r0 >= 0 && cyc - r0 < 256) bl[cyc - r0] = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int i, input int t, input logic [3:0] c,
                          input logic [2:0] b, input logic [13:0] ad);
        if (i >= log_q.size()) begin
            chk({tag, ".missing"}, log_q.size(), i + 1);
            return;
        end
        chk({tag, ".t"}, log_q[i].t, t);
        chk({tag, ".cmd"}, log_q[i].c, c);
        chk({tag, ".ba"}, log_q[i].b, b);
        chk({tag, ".a"}, log_q[i].ad, ad);
    endtask

    task automatic wait_n(input int n);
        int k = 0;
        while (log_q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("evcount", log_q.size(), n);
    endtask

    task automatic rst_a();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        r0 = cyc;
        log_q.delete();
    endtask

    task automatic drive(input logic w, input logic ap, input logic [2:0] b,
                         input logic [13:0] row, input logic [9:0] col);
        rq.write = w;
        rq.ap    = ap;
        rq.ba    = b;
        rq.row   = row;
        rq.col   = col;
        rq.valid = 1'b1;
    endtask

    initial begin
        int d, acc0, nb;
        rq.valid = 0; rq.write = 0; rq.ap = 0; rq.ba = 0; rq.row = 0; rq.col = 0;
        rqb.valid = 0; rqb.write = 0; rqb.ap = 0; rqb.ba = 0; rqb.row = 0; rqb.col = 0;
        repeat (2) @(negedge clk);
        chk("rst.cmd", {cs, ras, cas, we}, CMD_NOP);
        chk("rst.ba", ba, 0);
        chk("rst.a", a, 0);
        chk("rst.busy", busy, 0);
        chk("rst.ovr", ovr, 0);
        chk("rst.ready", rq.ready, 0);

        rst_b = 1'b1;
        repeat (6) @(negedge clk);
        chk("b.ref", {cs_b, ras_b, cas_b, we_b}, CMD_REF);
        chk("b.ba", ba_b, 0);
        chk("b.a", a_b, 0);
        repeat (5) @(negedge clk);
        chk("b.busy_t11", busy_b, 1);
        chk("b.ovr_t11", ovr_b, 0);
        @(negedge clk);
        chk("b.ovr_t12", ovr_b, 1);
        repeat (50) @(negedge clk);
        chk("b.ovr_sticky", ovr_b, 1);

        rst_a();
        acc0 = acc;
        drive(0, 0, 2, 14'h0123, 10'h045);
        wait_n(2);
        rq.valid = 0;
        chk_ev("t1.act", 0, 2, CMD_ACT, 2, 14'h0123);
        chk_ev("t1.rd", 1, 7, CMD_RD, 2, 14'h0045);
        chk("t1.acc", acc - acc0, 1);

        d = cyc - r0;
        drive(1, 1, 2, 14'h0123, 10'h07F);
        wait_n(3);
        rq.valid = 0;
        chk_ev("t2.wr", 2, d + 1, CMD_WR, 2, 14'h047F);

        d = cyc - r0;
        drive(0, 0, 2, 14'h0123, 10'h000);
        wait_n(5);
        rq.valid = 0;
        chk_ev("t2.closed_act", 3, d + 2, CMD_ACT, 2, 14'h0123);
        chk_ev("t2.closed_rd", 4, d + 7, CMD_RD, 2, 14'h0000);

        d = cyc - r0;
        drive(0, 0, 3, 14'h0005, 10'h001);
        wait_n(7);
        rq.valid = 0;
        chk_ev("t3.act5", 5, d + 2, CMD_ACT, 3, 14'h0005);
        chk_ev("t3.rd5", 6, d + 7, CMD_RD, 3, 14'h0001);

        d = cyc - r0;
        drive(0, 0, 3, 14'h0009, 10'h002);
        wait_n(10);
        rq.valid = 0;
        chk_ev("t3.pre", 7, d + 2, CMD_PRE, 3, 14'h0000);
        chk_ev("t3.act9", 8, d + 7, CMD_ACT, 3, 14'h0009);
        chk_ev("t3.rd9", 9, d + 12, CMD_RD, 3, 14'h0002);
        chk("t3.acc", acc - acc0, 5);

        rst_a();
        drive(0, 0, 1, 14'h02AA, 10'h003);
        wait_n(2);
        rq.valid = 0;
        while (cyc - r0 < 100) @(negedge clk);
        drive(0, 0, 1, 14'h02AA, 10'h004);
        #1;
        chk("t4.ready_blocked", rq.ready, 0);
        acc0 = acc;
        wait_n(6);
        rq.valid = 0;
        chk_ev("t4.prea", 2, 102, CMD_PRE, 0, 14'h0400);
        chk_ev("t4.ref", 3, 107, CMD_REF, 0, 14'h0400);
        chk_ev("t4.act", 4, 118, CMD_ACT, 1, 14'h02AA);
        chk_ev("t4.rd", 5, 123, CMD_RD, 1, 14'h0004);
        chk("t4.acc", acc - acc0, 1);
        nb = 0;
        for (int i = 101; i <= 116; i++) nb += int'(bl[i]);
        chk("t4.busy_cycles", nb, 15);
        chk("t4.idle_after_rfc", bl[116], 0);
        chk("t4.ovr", ovr, 0);

        rst_a();
        drive(0, 0, 4, 14'h00AB, 10'h005);
        wait_n(1);
        chk_ev("t6.act", 0, 2, CMD_ACT, 4, 14'h00AB);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_cmd", {cs, ras, cas, we}, CMD_NOP);
        chk("t6.rst_busy", busy, 0);
        chk("t6.rst_a", a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        r0 = cyc;
        log_q.delete();
        wait_n(2);
        rq.valid = 0;
        chk_ev("t6.act_again", 0, 2, CMD_ACT, 4, 14'h00AB);
        chk_ev("t6.rd", 1, 7, CMD_RD, 4, 14'h0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr3_cmd_sequencer.md
Name: ddr3_cmd_sequencer

Overview:
Parametrised DDR3 command sequencer that follows the single-bank command state machine. It tracks open rows for NUM_BANKS banks and enforces tRCD, tRP and tRFC with a shared wait counter. It auto-schedules periodic refresh (tREFI) and turns a valid/ready read/write request stream into registered CS/RAS/CAS/WE/BA/A pin commands. It sits between the host request port and the DRAM PHY pins.

Parameters:
NUM_BANKS, 8, number of banks tracked (power of 2)
BA_W, 3, bank address width, clog2(NUM_BANKS)
ROW_W, 14, row address width and A bus width (must be >= 11)
COL_W, 10, column width (must be <= 10; drives A[COL_W-1:0])
T_RCD, 5, cycles from ACT edge to RD/WR edge (>= 1)
T_RP, 5, cycles from PRE/PREA edge to next ACT/REF edge (>= 1)
T_RFC, 10, cycles from REF edge to next command edge (>= 1)
T_REFI, 100, refresh interval in cycles

Ports:
CLK  in  1  clock; all logic is on the rising edge
RESET_N  in  1  asynchronous, active-low reset
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted this cycle (combinational)
REQ_WRITE  in  1  1 = write, 0 = read
REQ_AP  in  1  auto-precharge after the access
REQ_BA  in  BA_W  target bank
REQ_ROW  in  ROW_W  target row
REQ_COL  in  COL_W  target column
CS, RAS, CAS, WE  out  1 each  registered active-low command pins
BA  out  BA_W  registered bank address
A  out  ROW_W  registered address bus
REF_OVERRUN  out  1  sticky flag: tREFI expired while a refresh was still pending
BUSY  out  1  high when the state is not IDLE

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE; pins = NOP (CS0 RAS1 CAS1 WE1); BA=0, A=0.
  - All open bits cleared; refresh timer=0; ref_pending=0; REF_OVERRUN=0.
  - Reset mid-operation aborts everything. Any accepted request in flight is lost.
- Command encodings:
  - ACT = 0011, with A=row.
  - RD = 0101; WR = 0100; A[COL_W-1:0]=col, A[10]=AP, other A bits 0.
  - PRE = 0010 with A10=0; PREA = 0010 with A10=1, BA=0.
  - REF = 0001.
  - Every command lasts exactly one cycle; all other cycles are NOP.
- Per-bank state: open[NUM_BANKS] and row[NUM_BANKS][ROW_W].
  - ACT sets open and row for the bank.
  - PRE, RD/WR with AP, and PREA clear open.
- Refresh timer:
  - Free-running; when it reaches T_REFI-1 it wraps to 0 and sets ref_pending.
  - If ref_pending is already 1 at expiry, REF_OVERRUN is set and stays set until reset.
  - Issuing REF clears ref_pending. Expiry and issue in the same cycle: pending stays 1, no overrun.
- Requester holds all REQ_* fields stable while REQ_VALID && !REQ_READY.
- FSM states: IDLE, PRE_ONE, ACT, WAIT, ISSUE, PREA, REF. The WAIT counter is loaded with T-1 and continues to a target state when it reaches 0.
- IDLE decision priority:
  1. ref_pending and any bank open -> drive PREA, then WAIT(T_RP) -> REF.
  2. ref_pending and no bank open -> REF.
  3. REQ_VALID with a row hit (open and row equal) -> REQ_READY=1; RD/WR is driven on the same edge; stay in IDLE (zero added latency).
  4. REQ_VALID, bank open, row mismatch -> PRE_ONE (PRE to REQ_BA), WAIT(T_RP) -> ACT.
  5. REQ_VALID, bank closed -> ACT.
  - Refresh pending blocks new acceptance: REQ_READY=0.
- ACT: drives ACT, then WAIT(T_RCD) -> ISSUE.
- ISSUE: REQ_READY=1; drives RD/WR -> IDLE.
- REF: drives REF, then WAIT(T_RFC) -> IDLE.
- Timing guarantee: ACT at edge n means RD/WR at edge n+T_RCD, with NOP in between. T=1 means no WAIT cycles.
- Refresh becoming pending mid-sequence does not preempt. The current request completes first.

Decomposition:
- Package ddr3_cmd_pkg holds:
  - Command encoding constants (NOP/ACT/RD/WR/PRE/REF as 4-bit {CS,RAS,CAS,WE}).
  - FSM state localparams.
  - The A10 index.
- One sub-module, ddr3_refresh_timer: holds the tREFI counter, ref_pending and REF_OVERRUN, with a ref_issued input.

Test Plan:
- Reset then a read of bank 2, row 0x0123, col 0x045, AP=0 -> ACT (BA=2, A=0x0123) at edge 1; RD (A=0x045) at edge 6; REQ_READY high one cycle; 4 NOPs between.
- Same bank and row again, write, AP=1 -> WR on the accept edge with A[10]=1; bank 2 closed afterwards.
- Bank 3 open at row 5, request row 9 -> PRE (BA=3, A10=0), 5 cycles, ACT row 9, 5 cycles, RD.
- Bank open when tREFI expires (cycle 99) -> PREA (A10=1), REF 5 cycles later, BUSY for T_RFC, REQ_READY=0 throughout; REF_OVERRUN stays 0.
- Hold the FSM in a long request stream so refresh is delayed past 2×T_REFI -> REF_OVERRUN=1 and it stays 1.
- Assert RESET_N=0 during WAIT after ACT -> pins NOP immediately; after release, the same request issues ACT again.
